// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the multi-digit BCD counter.
// Used by bcd_digit and bcd_counter via import bcd_pkg::*.
package bcd_pkg;

  localparam int         BCD_W      = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 8;

  // Decimal integer to packed BCD, digit 0 in bits [3:0]; evaluated at elaboration.
  function automatic logic [BCD_W*MAX_DIGITS-1:0] to_bcd(input int unsigned val);
    logic [BCD_W*MAX_DIGITS-1:0] r;
    int unsigned                 v;
    r = '0;
    v = val;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[BCD_W*i +: BCD_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with ripple carry (up) / borrow (down) chaining.
// carry_in/carry_out carry the borrow when dec is asserted.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             inc,
  input  logic             dec,
  input  logic             carry_in,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d   = digit_q;
    carry_out = 1'b0;
    if (inc) begin
      carry_out = carry_in && (digit_q == BCD_MAX);
    end else if (dec) begin
      carry_out = carry_in && (digit_q == '0);
    end

    if (ld) begin
      digit_d = ld_val;
    end else if (inc && carry_in) begin
      digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
    end else if (dec && carry_in) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign q = digit_q;

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with load, programmable maximum and tc pulse.
// Define BCD_COUNTER_SATURATE_EN to saturate at 0/MAX_VAL instead of wrapping.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int MAX_VAL = 999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc
);

  localparam int CW = 4 * DIGITS;
  localparam logic [CW-1:0] MAX_BCD = CW'(to_bcd(MAX_VAL));
`ifdef BCD_COUNTER_SATURATE_EN
  localparam logic [CW-1:0] PRE_MAX_BCD = CW'(to_bcd(MAX_VAL - 1));
  localparam logic [CW-1:0] ONE_BCD     = CW'(to_bcd(1));
`endif

  logic [CW-1:0]   count_w;
  logic [CW-1:0]   clamped;
  logic [CW-1:0]   load_sel;
  logic [CW-1:0]   ld_vec;
  logic [DIGITS:0] carry;
  logic            inc_req;
  logic            dec_req;
  logic            wrap_up;
  logic            wrap_dn;
  logic            ld_all;
  logic            tc_q;
  logic            tc_d;

  assign inc_req  = en && !load && up;
  assign dec_req  = en && !load && !up;
  assign carry[0] = 1'b1;

  // A full borrow out of the top digit means every digit was 0.
  assign wrap_up = inc_req && (count_w == MAX_BCD);
  assign wrap_dn = dec_req && carry[DIGITS];

  // Clamped BCD digits compare numerically as a plain unsigned vector.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      clamped[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
    end
    load_sel = (clamped > MAX_BCD) ? MAX_BCD : clamped;
  end

  always_comb begin
    ld_all = load || wrap_up || wrap_dn;
    ld_vec = load_sel;
    tc_d   = 1'b0;
    if (!load) begin
`ifdef BCD_COUNTER_SATURATE_EN
      ld_vec = wrap_up ? MAX_BCD : '0;
      tc_d   = (inc_req && (count_w == PRE_MAX_BCD)) ||
               (dec_req && (count_w == ONE_BCD));
`else
      ld_vec = wrap_up ? '0 : MAX_BCD;
      tc_d   = wrap_up || wrap_dn;
`endif
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .ld        (ld_all),
      .ld_val    (ld_vec[4*gi +: 4]),
      .inc       (inc_req),
      .dec       (dec_req),
      .carry_in  (carry[gi]),
      .q         (count_w[4*gi +: 4]),
      .carry_out (carry[gi+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign count = count_w;
  assign tc    = tc_q;

endmodule

// File: tb/tb_bcd_counter.sv
// Randomized + directed bench for bcd_counter (MAX_VAL=999 and MAX_VAL=59 instances).
// Honours BCD_COUNTER_SATURATE_EN when defined for the whole build.
module tb_bcd_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        up;
  logic        load;
  logic [11:0] load_val;
  logic [11:0] count_a;
  logic [11:0] count_b;
  logic        tc_a;
  logic        tc_b;

  int vectors     = 0;
  int miscompares = 0;

  int m_cnt [2];
  bit m_tc  [2];
  int m_max [2] = '{999, 59};

  always #5 clk = ~clk;

  bcd_counter #(.DIGITS(3), .MAX_VAL(999)) u_dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count_a), .tc(tc_a)
  );

  bcd_counter #(.DIGITS(3), .MAX_VAL(59)) u_dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count_b), .tc(tc_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [11:0] v);
    int r = 0;
    for (int i = 2; i >= 0; i--) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  function automatic bit sat_mode();
`ifdef BCD_COUNTER_SATURATE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge(input bit rst_n, input bit ld, input logic [11:0] lv,
                            input bit e, input bit u);
    for (int k = 0; k < 2; k++) begin
      int mx = m_max[k];
      m_tc[k] = 1'b0;
      if (!rst_n) begin
        m_cnt[k] = 0;
      end else if (ld) begin
        m_cnt[k] = (bcd2int(lv) > mx) ? mx : bcd2int(lv);
      end else if (e && u) begin
        if (m_cnt[k] < mx) begin
          m_cnt[k]++;
          m_tc[k] = sat_mode() && (m_cnt[k] == mx);
        end else if (!sat_mode()) begin
          m_cnt[k] = 0;
          m_tc[k]  = 1'b1;
        end
      end else if (e && !u) begin
        if (m_cnt[k] > 0) begin
          m_cnt[k]--;
          m_tc[k] = sat_mode() && (m_cnt[k] == 0);
        end else if (!sat_mode()) begin
          m_cnt[k] = mx;
          m_tc[k]  = 1'b1;
        end
      end
    end
  endtask

  // Apply one clock with the given inputs, then compare both DUTs to the model.
  task automatic clk_step(input bit rst_n, input bit ld, input logic [11:0] lv,
                          input bit e, input bit u);
    reset = rst_n; load = ld; load_val = lv; en = e; up = u;
    @(posedge clk);
    model_edge(rst_n, ld, lv, e, u);
    #1;
    check_val("cnt_a", 32'(count_a), 32'(int2bcd(m_cnt[0])));
    check_val("tc_a",  32'(tc_a),    32'(m_tc[0]));
    check_val("cnt_b", 32'(count_b), 32'(int2bcd(m_cnt[1])));
    check_val("tc_b",  32'(tc_b),    32'(m_tc[1]));
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;

    // Reset dominates load and en
    clk_step(0, 1, 12'h555, 1, 1);
    clk_step(0, 1, 12'h555, 1, 1);
    check_val("rst_cnt", 32'(count_a), 32'h000);
    check_val("rst_tc",  32'(tc_a),    32'h0);
    for (int i = 0; i < 10; i++) clk_step(1, 0, 12'h000, 1, 1);
    check_val("up10", 32'(count_a), 32'h010);
    for (int i = 0; i < 90; i++) clk_step(1, 0, 12'h000, 1, 1);
    check_val("up100", 32'(count_a), 32'h100);

`ifndef BCD_COUNTER_SATURATE_EN
    clk_step(1, 1, 12'h998, 0, 1);
    clk_step(1, 0, 12'h000, 1, 1);
    check_val("t2_999", 32'(count_a), 32'h999);
    check_val("t2_tc0", 32'(tc_a),    32'h0);
    clk_step(1, 0, 12'h000, 1, 1);
    check_val("t2_000", 32'(count_a), 32'h000);
    check_val("t2_tc1", 32'(tc_a),    32'h1);
    clk_step(1, 0, 12'h000, 1, 1);
    check_val("t2_001", 32'(count_a), 32'h001);
    check_val("t2_tc2", 32'(tc_a),    32'h0);

    clk_step(1, 1, 12'h000, 0, 0);
    clk_step(1, 0, 12'h000, 1, 0);
    check_val("t3_999", 32'(count_a), 32'h999);
    check_val("t3_tc1", 32'(tc_a),    32'h1);
    clk_step(1, 0, 12'h000, 1, 0);
    check_val("t3_998", 32'(count_a), 32'h998);
    check_val("t3_tc0", 32'(tc_a),    32'h0);
`endif

    clk_step(1, 1, 12'h0FA, 0, 1);
    check_val("t4_cap", 32'(count_b), 32'h059);
`ifndef BCD_COUNTER_SATURATE_EN
    clk_step(1, 0, 12'h000, 1, 1);
    check_val("t4_wrap", 32'(count_b), 32'h000);
    check_val("t4_tc",   32'(tc_b),    32'h1);
`endif

    clk_step(1, 1, 12'h123, 1, 1);
    check_val("t5_load", 32'(count_a), 32'h123);
    for (int i = 0; i < 5; i++) clk_step(1, 0, 12'h456, 0, 1);
    check_val("t5_hold", 32'(count_a), 32'h123);
    check_val("t5_tc",   32'(tc_a),    32'h0);
    clk_step(0, 1, 12'h777, 1, 1);
    check_val("t5_rst", 32'(count_a), 32'h000);

`ifdef BCD_COUNTER_SATURATE_EN
    clk_step(1, 1, 12'h998, 0, 1);
    clk_step(1, 0, 12'h000, 1, 1);
    check_val("t6_hit",  32'(count_a), 32'h999);
    check_val("t6_tc1",  32'(tc_a),    32'h1);
    for (int i = 0; i < 3; i++) begin
      clk_step(1, 0, 12'h000, 1, 1);
      check_val("t6_hold", 32'(count_a), 32'h999);
      check_val("t6_tc0",  32'(tc_a),    32'h0);
    end
    clk_step(1, 1, 12'h000, 0, 0);
    clk_step(1, 0, 12'h000, 1, 0);
    check_val("t6_zero",  32'(count_a), 32'h000);
    check_val("t6_ztc",   32'(tc_a),    32'h0);
`endif

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      bit          r_n = ($urandom_range(99) != 0);
      bit          ld  = ($urandom_range(19) == 0);
      bit          e   = ($urandom_range(9) < 7);
      bit          u   = $urandom_range(1);
      logic [11:0] lv  = 12'($urandom);
      if ($urandom_range(3) == 0) lv = int2bcd($urandom_range(999));
      clk_step(r_n, ld, lv, e, u);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
